sdp_x_alu_in_pipe_fifo: RTL
===========================

Name: sdp_x_alu_in_pipe_fifo

Overview:
- Buffering stage directly upstream of the X ALU core input channel interface (the chn_alu_in wire-wait receiver).
- Accepts 512-bit ALU operand beats from the SDP datapath on a valid/ready handshake.
- Stores up to DEPTH beats and presents the head beat on the wire-wait output pair (z/vz); the consumer acknowledges each beat with lz.
- Decouples upstream stalls from the core's load timing.

Parameters:
- WIDTH, 512, data beat width in bits.
- DEPTH, 4, number of storage entries; must be a power of 2, minimum 2.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- nvdla_core_clk  input  1  core clock; all state updates on the rising edge.
- nvdla_core_rst  input  1  asynchronous reset, active-high.
- alu_in_pvld  input  1  upstream beat valid.
- alu_in_prdy  output  1  upstream ready; equals !full.
- alu_in_pd  input  WIDTH  upstream beat data.
- chn_alu_in_rsc_z  output  WIDTH  head-of-queue data to the core.
- chn_alu_in_rsc_vz  output  1  head valid; equals !empty.
- chn_alu_in_rsc_lz  input  1  core load strobe; a pop occurs when vz and lz are both high.
- fifo_count  output  AW+1  current occupancy, 0..DEPTH.
- fifo_ovf_err  output  1  sticky error flag: lz was seen while vz was low.

Behaviour:
- Reset (async assert, sync-safe deassert by system): wr_ptr=0, rd_ptr=0, count=0, fifo_ovf_err=0. Storage contents are not reset.
- Output values during reset:
  - alu_in_prdy=1
  - chn_alu_in_rsc_vz=0
  - chn_alu_in_rsc_z = don't care; the bench must not check z while vz=0.
  - fifo_count=0
- Push: alu_in_pvld & alu_in_prdy. At the clock edge, mem[wr_ptr] <= alu_in_pd and wr_ptr <= wr_ptr+1 (mod DEPTH).
- Pop: chn_alu_in_rsc_vz & chn_alu_in_rsc_lz. At the clock edge, rd_ptr <= rd_ptr+1 (mod DEPTH).
- Count update: count <= count + push - pop.
  - empty = (count==0); full = (count==DEPTH).
  - Pointers wrap naturally at DEPTH.
- Output timing:
  - chn_alu_in_rsc_z = mem[rd_ptr], combinational read from registered state.
  - Latency: a beat pushed at edge N is visible on z/vz after edge N.
  - Minimum pass-through latency is 1 cycle; there is no same-cycle bypass.
- Readiness: alu_in_prdy depends only on registered count. There is no combinational path from lz to prdy.
  - When full, prdy=0 even if a pop occurs in the same cycle. Upstream sees ready on the next cycle.
- Simultaneous push and pop when 0<count<DEPTH: count is unchanged and both pointers advance.
- Empty case:
  - A push alone makes vz high next cycle.
  - lz with vz=0 is ignored: no pointer movement. It sets fifo_ovf_err=1, which stays set until reset.
- Full case: alu_in_pvld is held off by prdy=0. Data on alu_in_pd is ignored and no storage write occurs.
- Wire-wait contract:
  - z and vz remain stable until a pop occurs.
  - The head entry is never overwritten while count>0, since wr_ptr==rd_ptr only when count is 0 or DEPTH, and no push is allowed at DEPTH.
- Reset mid-operation: all queued beats are discarded and vz drops immediately (async). After release, the block behaves as freshly empty.
- fifo_count is registered and reflects the post-edge occupancy.

Test Plan:
- Reset then idle → prdy=1, vz=0, fifo_count=0, fifo_ovf_err=0.
- Push 0xA5 replicated across 512 bits with lz=0 → after 1 edge, vz=1, z=0xA5..A5, count=1. Hold lz=0 for 5 cycles → z and vz unchanged.
- Push 4 beats (values 1,2,3,4) with lz=0 → count=4, prdy=0. A fifth pvld with data 5 is not accepted. Raise lz for 4 cycles → z sequence 1,2,3,4, then vz=0 and count=0.
- Streaming: pvld=1 and lz=1 every cycle for 20 beats of incrementing data → after the 1-cycle fill, count stays 1, output order matches input, no beat is lost across pointer wrap (>DEPTH beats).
- Full plus simultaneous pop: at count=4, assert lz=1 and pvld=1 → that cycle prdy=0 and count becomes 3. Next cycle prdy=1, the beat is accepted and count returns to 4.
- Pulse lz=1 while empty → fifo_ovf_err=1 and stays 1. Assert nvdla_core_rst mid-stream with count=3 → vz=0 and count=0 immediately, fifo_ovf_err=0.

Source files
------------

// File: rtl/sdp_x_alu_in_pipe_fifo_if.sv
// Handshake bundle between the SDP datapath, the ALU-input FIFO and the X ALU core.
// The slave modport is the FIFO side; the master modport is the surrounding logic.
interface sdp_x_alu_in_pipe_fifo_if #(
  parameter int WIDTH = 512,
  parameter int AW    = 2
);
  logic             alu_in_pvld;
  logic             alu_in_prdy;
  logic [WIDTH-1:0] alu_in_pd;
  logic [WIDTH-1:0] chn_alu_in_rsc_z;
  logic             chn_alu_in_rsc_vz;
  logic             chn_alu_in_rsc_lz;
  logic [AW:0]      fifo_count;
  logic             fifo_ovf_err;

  modport slave (
    input  alu_in_pvld, alu_in_pd, chn_alu_in_rsc_lz,
    output alu_in_prdy, chn_alu_in_rsc_z, chn_alu_in_rsc_vz, fifo_count, fifo_ovf_err
  );

  modport master (
    output alu_in_pvld, alu_in_pd, chn_alu_in_rsc_lz,
    input  alu_in_prdy, chn_alu_in_rsc_z, chn_alu_in_rsc_vz, fifo_count, fifo_ovf_err
  );
endinterface

// File: rtl/sdp_x_alu_in_pipe_fifo.sv
// Buffers ALU operand beats ahead of the X ALU core's wire-wait input channel.
// Ready and head-valid come only from registered occupancy, so lz never reaches prdy.
module sdp_x_alu_in_pipe_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic nvdla_core_clk,
  input logic nvdla_core_rst,
  sdp_x_alu_in_pipe_fifo_if.slave bus
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_ovf_err;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_push  = bus.alu_in_pvld & ~w_full;
  assign w_pop   = bus.chn_alu_in_rsc_lz & ~w_empty;

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      // A load strobe against an empty queue is a consumer protocol error; keep it sticky.
      if (bus.chn_alu_in_rsc_lz & w_empty) r_ovf_err <= 1'b1;
    end
  end

  // Storage is deliberately not reset; only the pointers define what is valid.
  always_ff @(posedge nvdla_core_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.alu_in_pd;
  end

  assign bus.alu_in_prdy       = ~w_full;
  assign bus.chn_alu_in_rsc_vz = ~w_empty;
  assign bus.chn_alu_in_rsc_z  = r_mem[r_rd_ptr];
  assign bus.fifo_count        = r_count;
  assign bus.fifo_ovf_err      = r_ovf_err;

endmodule
